bta_reduce_sched: RTL and testbench
===================================

# bta_reduce_sched

Sequenced multi-operand reduction controller for the binary-tree-adder family. It accepts `N` unsigned `m`-bit operands over a valid/ready stream and buffers them. It then reduces them in binary-tree order using one shared adder, at one addition per clock, and presents the `m+$clog2(N)`-bit total on a valid/ready output. It is the low-area, time-multiplexed counterpart to the fully parallel tree adders, and is used where operands arrive serially.

## Interface
- `N`, 8, number of operands per reduction; power of two, 2 ≤ N ≤ 32
- `m`, 16, operand width in bits
- `clk`  in  1  clock; all state updates on posedge
- `rst`  in  1  synchronous, active-high reset
- `clr`  in  1  synchronous abort; discards the current reduction
- `in_valid`  in  1  operand present on `in_data`
- `in_ready`  out  1  block accepts an operand this cycle
- `in_data`  in  m  unsigned operand
- `out_valid`  out  1  `out_sum` holds a completed total
- `out_ready`  in  1  consumer takes `out_sum`
- `out_sum`  out  m+$clog2(N)  unsigned sum of the N accepted operands
- `busy`  out  1  high in REDUCE or DONE

## Operation
- Storage: `N` slots `slot[0..N-1]`, each `m+$clog2(N)` bits wide. The operand count `ld_cnt` is `$clog2(N)+1` bits. The level counter `lvl` (1..$clog2(N)) and pair index `pk` are registered.
- There is one adder of width `m+$clog2(N)`. Its carry-in is 0. Its carry-out is discarded; this cannot overflow by construction.
- State LOAD:
  - `in_ready`=1.
  - On `in_valid && in_ready`, `slot[ld_cnt]` takes the zero-extended `in_data` and `ld_cnt` increments.
  - When the N-th operand is accepted, the state goes to REDUCE with `lvl`=1 and `pk`=0.
- State REDUCE:
  - `in_ready`=0.
  - Each cycle performs one addition: `slot[pk·2^lvl] <= slot[pk·2^lvl] + slot[pk·2^lvl + 2^(lvl-1)]`.
  - `pk` increments. When `pk` reaches `N/2^lvl − 1`, `pk` clears and `lvl` increments.
  - The final addition is at `lvl`=$clog2(N), `pk`=0. The state then goes to DONE.
  - The total is exactly N−1 additions, in fixed tree order: level 1 pairs adjacent operands, and each later level pairs the prior partial sums.
- State DONE:
  - `out_valid`=1 and `out_sum`=`slot[0]`, both stable until `out_ready`.
  - On `out_valid && out_ready`, the state goes to LOAD and `ld_cnt`=0.
  - `in_ready` stays 0 in DONE, including the handshake cycle. The next operand can be accepted in the following cycle at the earliest.
- `clr` (when `rst`=0) in any state: next state LOAD, `ld_cnt`/`lvl`/`pk` cleared, `out_valid`=0. Slot contents are don't-care and are fully overwritten by the next load.
- `rst` has priority over `clr`, and `clr` has priority over every handshake in the same cycle.
- Only unsigned arithmetic is used. Operand order does not affect the result.

## Timing
- Reset values:
  - state=LOAD; `in_ready`=1 from the first cycle after reset; `out_valid`=0; `out_sum`=0; `busy`=0
  - `ld_cnt`=0, `lvl`=1, `pk`=0, all slots 0
- All outputs are registered or decoded from registered state only. There are no combinational paths from `in_valid` or `out_ready` to any output.
- Latency:
  - The last operand is accepted at edge E0.
  - Additions occur at edges E1..E(N−1).
  - `out_valid` is high in the cycle after E(N−1). For N=8 that is 7 cycles after the last-accept edge.
- Throughput with no stalls is one reduction per 2N cycles: N load cycles, N−1 reduce cycles, and at least 1 DONE cycle.
- Gaps in `in_valid` during LOAD only extend LOAD. Partial counts are held indefinitely.
- `out_ready` low in DONE holds all state, with no limit on duration.
- `rst` or `clr` asserted in mid-REDUCE takes effect at that edge. The partial result is never presented.

## Test plan
- N=8, m=16: load 1..8 back-to-back with `out_ready`=1 → `out_valid` rises exactly 7 cycles after the 8th accept, `out_sum`=36, one-cycle pulse; next cycle `in_ready`=1.
- Eight operands of 0xFFFF → `out_sum`=0x7FFF8 (19 bits) with no truncation. Eight zeros → 0.
- `out_ready` held low 5 cycles in DONE → `out_sum` and `out_valid` stable and `in_ready`=0 throughout; the handshake in cycle 6 returns the block to LOAD.
- `in_valid` toggled 1,0,1,0… with operands 0x1000,0x2000,…,0x8000 → `out_sum`=0x24000. No operand is captured while `in_valid`=0.
- `clr` after 5 operands, then load 10,20,…,80 → `out_sum`=360 with no contribution from the aborted operands. Repeat with `clr` in REDUCE cycle 3 → no `out_valid`; the next full load gives the correct sum.
- `rst` pulsed in REDUCE, then in DONE with `out_ready`=0 → the next cycle shows every output at its reset value and the block in LOAD. Also run N=2, m=4 with inputs 0xF,0xF → `out_sum`=0x1E, `out_valid` 1 cycle after the 2nd accept.

Source files
------------

// File: rtl/bta_reduce_sched_if.sv
// Operand/result stream bundle for bta_reduce_sched.
// master: operand producer and result consumer (drives in_valid/in_data/out_ready).
// slave : the reduction block (drives in_ready/out_valid/out_sum).
interface bta_reduce_sched_if #(
  parameter int N = 8,
  parameter int m = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic [m-1:0]            in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [m+$clog2(N)-1:0]  out_sum;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum
  );
endinterface

// File: rtl/bta_reduce_sched.sv
// Time-multiplexed binary-tree reduction of N unsigned m-bit operands.
// Operands are buffered during LOAD, then summed pairwise in tree order with
// one shared adder (one addition per clock), and the total is offered on the
// output stream in DONE.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset
//   clr   - synchronous abort of the current reduction
//   busy  - high in REDUCE or DONE
//   bus   - slave side of the operand/result stream (bta_reduce_sched_if)
//
// state  | meaning
// LOAD   | accepting operands into slot[ld_cnt]
// REDUCE | one tree addition per cycle, level lvl, pair pk
// DONE   | slot[0] presented on out_sum until taken
module bta_reduce_sched #(
  parameter int N = 8,
  parameter int m = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic busy,
  bta_reduce_sched_if.slave bus
);
  localparam int LG = $clog2(N);
  localparam int W  = m + LG;
  localparam logic [LG-1:0] PK_ONE  = 1;
  localparam logic [LG:0]   CNT_ONE = 1;
  localparam logic [LG:0]   CNT_LAST = (LG+1)'(N - 1);
  localparam logic [LG:0]   LVL_TOP  = (LG+1)'(LG);

  typedef enum logic [1:0] {LOAD = 2'd0, REDUCE = 2'd1, DONE = 2'd2} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  slot [N];
  logic [LG:0]   ld_cnt, ld_cnt_nxt;
  logic [LG:0]   lvl, lvl_nxt;
  logic [LG-1:0] pk, pk_nxt;
  logic          load_fire, add_fire;
  logic [LG-1:0] base, partner, pk_last;
  logic [W-1:0]  sum;

  // Pair addressing: left operand at pk*2^lvl, right one half a stride further.
  always_comb begin
    base    = pk << lvl;
    partner = base + (PK_ONE << (lvl - CNT_ONE));
    pk_last = (LG)'((N >> lvl) - 1);
    // Carry-out is dropped: N m-bit operands always fit in m+log2(N) bits.
    sum     = slot[base] + slot[partner];
  end

  always_comb begin
    state_nxt  = state;
    ld_cnt_nxt = ld_cnt;
    lvl_nxt    = lvl;
    pk_nxt     = pk;
    load_fire  = 1'b0;
    add_fire   = 1'b0;
    if (clr) begin
      state_nxt  = LOAD;
      ld_cnt_nxt = '0;
      lvl_nxt    = CNT_ONE;
      pk_nxt     = '0;
    end else begin
      case (state)
        LOAD: begin
          if (bus.in_valid) begin
            load_fire  = 1'b1;
            ld_cnt_nxt = ld_cnt + CNT_ONE;
            if (ld_cnt == CNT_LAST) begin
              state_nxt = REDUCE;
              lvl_nxt   = CNT_ONE;
              pk_nxt    = '0;
            end
          end
        end
        REDUCE: begin
          add_fire = 1'b1;
          if (pk == pk_last) begin
            pk_nxt = '0;
            if (lvl == LVL_TOP) state_nxt = DONE;
            else                lvl_nxt   = lvl + CNT_ONE;
          end else begin
            pk_nxt = pk + PK_ONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_nxt  = LOAD;
            ld_cnt_nxt = '0;
            lvl_nxt    = CNT_ONE;
          end
        end
        default: state_nxt = LOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= LOAD;
      ld_cnt <= '0;
      lvl    <= CNT_ONE;
      pk     <= '0;
    end else begin
      state  <= state_nxt;
      ld_cnt <= ld_cnt_nxt;
      lvl    <= lvl_nxt;
      pk     <= pk_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) slot[i] <= '0;
    end else if (load_fire) begin
      slot[ld_cnt[LG-1:0]] <= {{LG{1'b0}}, bus.in_data};
    end else if (add_fire) begin
      slot[base] <= sum;
    end
  end

  // Outputs decode registered state only; no path from in_valid/out_ready.
  assign bus.in_ready  = (state == LOAD);
  assign bus.out_valid = (state == DONE);
  assign bus.out_sum   = (state == DONE) ? slot[0] : '0;
  assign busy          = (state != LOAD);
endmodule

// File: tb/tb_bta_reduce_sched.sv
module tb_bta_reduce_sched;
  logic clk = 1'b0;
  logic rst;
  logic clr;
  logic clr2;
  logic busy;
  logic busy2;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   lat;
  logic seen;

  always #5 clk = ~clk;

  bta_reduce_sched_if #(.N(8), .m(16)) bus8 ();
  bta_reduce_sched_if #(.N(2), .m(4))  bus2 ();

  bta_reduce_sched #(.N(8), .m(16)) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .busy(busy),
    .bus (bus8)
  );

  bta_reduce_sched #(.N(2), .m(4)) dut2 (
    .clk (clk),
    .rst (rst),
    .clr (clr2),
    .busy(busy2),
    .bus (bus2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Eight operands first, first+step, ...; optional idle cycle after each.
  task automatic load8(input logic [15:0] first, input logic [15:0] step, input bit gaps);
    logic [15:0] v;
    v = first;
    for (int i = 0; i < 8; i++) begin
      bus8.in_valid = 1'b1;
      bus8.in_data  = v;
      tick();
      v = v + step;
      if (gaps && i != 7) begin
        bus8.in_valid = 1'b0;
        bus8.in_data  = 16'hDEAD;
        tick();
      end
    end
    bus8.in_valid = 1'b0;
    bus8.in_data  = 16'hBEEF;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (bus8.out_valid !== 1'b1 && cycles < 40) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; clr2 = 1'b0;
    bus8.in_valid = 1'b0; bus8.in_data = '0; bus8.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.out_ready = 1'b0;
    tick(); tick();
    check("rst_in_ready",  32'(bus8.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus8.out_valid), 32'd0);
    check("rst_out_sum",   32'(bus8.out_sum), 32'd0);
    check("rst_busy",      32'(busy), 32'd0);
    rst = 1'b0;

    // 1..8 back to back
    bus8.out_ready = 1'b1;
    load8(16'd1, 16'd1, 1'b0);
    check("seq_busy_reduce", 32'(busy), 32'd1);
    wait_done(lat);
    check("seq_latency", 32'(lat), 32'd7);
    check("seq_sum", 32'(bus8.out_sum), 32'd36);
    check("seq_in_ready_done", 32'(bus8.in_ready), 32'd0);
    tick();
    check("seq_pulse", 32'(bus8.out_valid), 32'd0);
    check("seq_in_ready_after", 32'(bus8.in_ready), 32'd1);

    // all ones: full-width result without truncation
    load8(16'hFFFF, 16'h0000, 1'b0);
    wait_done(lat);
    check("max_sum", 32'(bus8.out_sum), 32'h7FFF8);
    tick();

    load8(16'h0000, 16'h0000, 1'b0);
    wait_done(lat);
    check("zero_valid", 32'(bus8.out_valid), 32'd1);
    check("zero_sum", 32'(bus8.out_sum), 32'd0);
    tick();

    // backpressure in DONE: 5,10,..,40 = 180
    bus8.out_ready = 1'b0;
    load8(16'd5, 16'd5, 1'b0);
    wait_done(lat);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(bus8.out_valid), 32'd1);
      check("stall_sum", 32'(bus8.out_sum), 32'd180);
      check("stall_in_ready", 32'(bus8.in_ready), 32'd0);
      tick();
    end
    check("stall6_sum", 32'(bus8.out_sum), 32'd180);
    bus8.out_ready = 1'b1;
    bus8.in_valid  = 1'b1;
    bus8.in_data   = 16'h7777;
    tick();
    bus8.in_valid = 1'b0;
    check("stall_release_valid", 32'(bus8.out_valid), 32'd0);
    check("stall_release_ready", 32'(bus8.in_ready), 32'd1);

    // in_valid gaps; 0x7777 above and 0xDEAD gaps must not be captured
    load8(16'h1000, 16'h1000, 1'b1);
    wait_done(lat);
    check("gap_sum", 32'(bus8.out_sum), 32'h24000);
    tick();

    // clr after 5 operands
    for (int i = 0; i < 5; i++) begin
      bus8.in_valid = 1'b1;
      bus8.in_data  = 16'h0100;
      tick();
    end
    bus8.in_valid = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_load_ready", 32'(bus8.in_ready), 32'd1);
    load8(16'd10, 16'd10, 1'b0);
    wait_done(lat);
    check("clr_load_latency", 32'(lat), 32'd7);
    check("clr_load_sum", 32'(bus8.out_sum), 32'd360);
    tick();

    // clr in REDUCE cycle 3
    load8(16'd1, 16'd1, 1'b0);
    tick(); tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_red_busy", 32'(busy), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus8.out_valid === 1'b1) seen = 1'b1;
      tick();
    end
    check("clr_red_no_valid", 32'(seen), 32'd0);
    load8(16'd3, 16'd3, 1'b0);
    wait_done(lat);
    check("clr_red_next_sum", 32'(bus8.out_sum), 32'd108);
    tick();

    // rst in REDUCE
    load8(16'd1, 16'd1, 1'b0);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstr_in_ready", 32'(bus8.in_ready), 32'd1);
    check("rstr_out_valid", 32'(bus8.out_valid), 32'd0);
    check("rstr_out_sum", 32'(bus8.out_sum), 32'd0);
    check("rstr_busy", 32'(busy), 32'd0);

    // rst in DONE while stalled
    bus8.out_ready = 1'b0;
    load8(16'd1, 16'd1, 1'b0);
    wait_done(lat);
    check("rstd_pre_valid", 32'(bus8.out_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstd_in_ready", 32'(bus8.in_ready), 32'd1);
    check("rstd_out_valid", 32'(bus8.out_valid), 32'd0);
    check("rstd_out_sum", 32'(bus8.out_sum), 32'd0);
    check("rstd_busy", 32'(busy), 32'd0);

    bus8.out_ready = 1'b1;
    load8(16'd2, 16'd2, 1'b0);
    wait_done(lat);
    check("post_rst_sum", 32'(bus8.out_sum), 32'd72);
    tick();

    // N=2, m=4
    bus2.out_ready = 1'b1;
    bus2.in_valid  = 1'b1;
    bus2.in_data   = 4'hF;
    tick();
    tick();
    bus2.in_valid = 1'b0;
    check("n2_not_yet", 32'(bus2.out_valid), 32'd0);
    tick();
    check("n2_valid", 32'(bus2.out_valid), 32'd1);
    check("n2_sum", 32'(bus2.out_sum), 32'h1E);
    tick();
    check("n2_back_to_load", 32'(bus2.in_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
